// File: rtl/ioctl_host.sv
// Host-side ioctl driver for the simulation top: streams an image into the core
// (download) and reads core memory back out (upload).
module ioctl_host #(
    parameter int         WR_GAP    = 3,
    parameter int         RD_LAT    = 2,
    parameter logic [7:0] UL_INDEX  = 8'd4,
    parameter int         UL_LENGTH = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_start,
    input  logic [7:0]  dl_index,
    input  logic [24:0] dl_length,
    output logic [24:0] src_addr,
    input  logic [7:0]  src_data,
    input  logic        ul_start,
    output logic        ioctl_download,
    output logic        ioctl_upload,
    input  logic        ioctl_upload_req,
    output logic        ioctl_wr,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_din,
    output logic [7:0]  ioctl_index,
    input  logic        ioctl_wait,
    output logic        ul_wr,
    output logic [24:0] ul_addr,
    output logic [7:0]  ul_data,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_DL_FETCH = 4'd1;
    localparam logic [3:0] S_DL_WRITE = 4'd2;
    localparam logic [3:0] S_DL_GAP   = 4'd3;
    localparam logic [3:0] S_DL_END   = 4'd4;
    localparam logic [3:0] S_UL_ADDR  = 4'd5;
    localparam logic [3:0] S_UL_WAIT  = 4'd6;
    localparam logic [3:0] S_UL_CAP   = 4'd7;
    localparam logic [3:0] S_UL_END   = 4'd8;

    localparam logic [15:0] GAP_LOAD = 16'(WR_GAP - 1);
    localparam logic [15:0] LAT_LOAD = 16'(RD_LAT - 1);
    localparam logic [25:0] UL_LEN26 = 26'(UL_LENGTH);

    logic [3:0]  r_state;
    logic [24:0] r_n;
    logic [24:0] r_len;
    logic [7:0]  r_index;
    logic [15:0] r_cnt;
    logic [24:0] r_ioctl_addr;
    logic [7:0]  r_dout;
    logic [24:0] r_ul_addr;
    logic [7:0]  r_ul_data;
    logic        r_req_d;
    logic        r_ul_pend;

    logic [25:0] w_n_inc;
    logic        w_dl_more;
    logic        w_ul_more;
    logic        w_ul_req;
    logic        w_in_dl;
    logic        w_in_ul;

    // 26-bit increment so UL_LENGTH = 2^25 terminates instead of wrapping.
    assign w_n_inc   = {1'b0, r_n} + 26'd1;
    assign w_dl_more = w_n_inc < {1'b0, r_len};
    assign w_ul_more = w_n_inc < UL_LEN26;
    assign w_ul_req  = ul_start | (ioctl_upload_req & ~r_req_d);
    assign w_in_dl   = (r_state == S_DL_FETCH) || (r_state == S_DL_WRITE) ||
                       (r_state == S_DL_GAP)   || (r_state == S_DL_END);
    assign w_in_ul   = (r_state == S_UL_ADDR) || (r_state == S_UL_WAIT) ||
                       (r_state == S_UL_CAP);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_len        <= '0;
            r_index      <= '0;
            r_cnt        <= '0;
            r_ioctl_addr <= '0;
            r_dout       <= '0;
            r_ul_addr    <= '0;
            r_ul_data    <= '0;
            r_req_d      <= 1'b0;
            r_ul_pend    <= 1'b0;
        end else begin
            r_req_d <= ioctl_upload_req;
            case (r_state)
                S_IDLE: begin
                    if (dl_start) begin
                        r_index <= dl_index;
                        r_len   <= dl_length;
                        r_n     <= '0;
                        r_state <= S_DL_FETCH;
                        if (w_ul_req) r_ul_pend <= 1'b1;
                    end else if (w_ul_req || r_ul_pend) begin
                        r_n          <= '0;
                        r_ioctl_addr <= '0;
                        r_ul_addr    <= '0;
                        r_ul_pend    <= 1'b0;
                        r_state      <= S_UL_ADDR;
                    end
                end
                S_DL_FETCH: begin
                    // Empty image: one gap cycle keeps ioctl_download up for two cycles.
                    if (r_len == 25'd0) begin
                        r_cnt   <= '0;
                        r_state <= S_DL_GAP;
                    end else if (!ioctl_wait) begin
                        r_ioctl_addr <= r_n;
                        r_state      <= S_DL_WRITE;
                    end
                end
                S_DL_WRITE: begin
                    r_dout  <= src_data;
                    r_cnt   <= GAP_LOAD;
                    r_state <= S_DL_GAP;
                end
                S_DL_GAP: begin
                    if (r_cnt == 16'd0) begin
                        if (w_dl_more) begin
                            r_n     <= w_n_inc[24:0];
                            r_state <= S_DL_FETCH;
                        end else begin
                            r_state <= S_DL_END;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DL_END: r_state <= S_IDLE;
                S_UL_ADDR: begin
                    r_cnt   <= LAT_LOAD;
                    r_state <= S_UL_WAIT;
                end
                S_UL_WAIT: begin
                    if (r_cnt == 16'd0) r_state <= S_UL_CAP;
                    else                r_cnt   <= r_cnt - 16'd1;
                end
                S_UL_CAP: begin
                    r_ul_data <= ioctl_din;
                    if (w_ul_more) begin
                        r_n          <= w_n_inc[24:0];
                        r_ioctl_addr <= w_n_inc[24:0];
                        r_ul_addr    <= w_n_inc[24:0];
                        r_state      <= S_UL_ADDR;
                    end else begin
                        r_state <= S_UL_END;
                    end
                end
                S_UL_END: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
            // Upload requests seen during a download are deferred, not dropped.
            if (w_in_dl && w_ul_req) r_ul_pend <= 1'b1;
        end
    end

    assign ioctl_download = (r_state == S_DL_FETCH) || (r_state == S_DL_WRITE) ||
                            (r_state == S_DL_GAP);
    assign ioctl_upload   = w_in_ul;
    assign ioctl_wr       = (r_state == S_DL_WRITE);
    assign ul_wr          = (r_state == S_UL_CAP);
    assign src_addr       = (r_state == S_DL_FETCH) ? r_n : 25'd0;
    assign ioctl_addr     = r_ioctl_addr;
    // Source data arrives in the write cycle itself; the register holds it afterwards.
    assign ioctl_dout     = (r_state == S_DL_WRITE) ? src_data : r_dout;
    assign ul_addr        = r_ul_addr;
    assign ul_data        = (r_state == S_UL_CAP) ? ioctl_din : r_ul_data;
    assign ioctl_index    = ioctl_download ? r_index : (w_in_ul ? UL_INDEX : 8'd0);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DL_END) || (r_state == S_UL_END);

endmodule

// File: tb/tb_ioctl_host.sv
// Bench for ioctl_host: scoreboarded download writes and upload captures with timing checks.
module tb_ioctl_host;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_start;
    logic [7:0]  dl_index;
    logic [24:0] dl_length;
    logic [24:0] src_addr;
    logic [7:0]  src_data;
    logic        ul_start;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic        ioctl_upload_req;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        ul_wr;
    logic [24:0] ul_addr;
    logic [7:0]  ul_data;
    logic        busy;
    logic        done;

    always #5 clk_sys = ~clk_sys;

    ioctl_host #(.WR_GAP(3), .RD_LAT(2), .UL_INDEX(8'd4), .UL_LENGTH(64)) dut (
        .clk_sys(clk_sys), .reset(reset), .dl_start(dl_start), .dl_index(dl_index),
        .dl_length(dl_length), .src_addr(src_addr), .src_data(src_data),
        .ul_start(ul_start), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_upload_req(ioctl_upload_req), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait), .ul_wr(ul_wr), .ul_addr(ul_addr), .ul_data(ul_data),
        .busy(busy), .done(done)
    );

    logic [7:0] img [0:15];
    always @(posedge clk_sys) src_data <= img[src_addr[3:0]];
    assign ioctl_din = ioctl_addr[7:0] ^ 8'h3C;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int          exp_dl_addr [$];
    logic [7:0]  exp_dl_data [$];
    int          exp_ul_addr [$];
    logic [7:0]  exp_ul_data [$];
    int          wr_cyc [$];
    int ul_count = 0, ul_last_cyc = 0, ul_starts = 0, ul_rise_cyc = 0, ul_fall_cyc = 0;
    int done_cnt = 0, done_cyc = 0, dl_hi = 0, dl_fall_cyc = 0;
    logic prev_dl = 1'b0, prev_ul = 1'b0;

    always @(negedge clk_sys) begin
        if (ioctl_wr) begin
            wr_cyc.push_back(cyc);
            if (exp_dl_addr.size() == 0) begin
                check("dl_extra_wr", ioctl_wr, 1'b0);
            end else begin
                int a;
                logic [7:0] d;
                a = exp_dl_addr.pop_front();
                d = exp_dl_data.pop_front();
                check("dl_wr_addr", ioctl_addr, a);
                check("dl_wr_data", ioctl_dout, d);
                $display("[TB] dl wr cyc=%0d addr=%0h data=%02h", cyc, ioctl_addr, ioctl_dout);
            end
        end
        if (ul_wr) begin
            ul_count++;
            ul_last_cyc = cyc;
            check("ul_index", ioctl_index, 8'd4);
            if (exp_ul_addr.size() == 0) begin
                check("ul_extra_wr", ul_wr, 1'b0);
            end else begin
                int a;
                logic [7:0] d;
                a = exp_ul_addr.pop_front();
                d = exp_ul_data.pop_front();
                check("ul_cap_addr", ul_addr, a);
                check("ul_cap_data", ul_data, d);
                $display("[TB] ul cap cyc=%0d addr=%0h data=%02h", cyc, ul_addr, ul_data);
            end
        end
        if (ioctl_upload) check("ul_no_ioctl_wr", ioctl_wr, 1'b0);
        if (ioctl_download) dl_hi++;
        if (prev_dl && !ioctl_download) dl_fall_cyc = cyc;
        if (!prev_ul && ioctl_upload) begin ul_starts++; ul_rise_cyc = cyc; end
        if (prev_ul && !ioctl_upload) ul_fall_cyc = cyc;
        prev_dl = ioctl_download;
        prev_ul = ioctl_upload;
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_download"}, ioctl_download, 1'b0);
        check({tag, "_upload"}, ioctl_upload, 1'b0);
        check({tag, "_wr"}, ioctl_wr, 1'b0);
        check({tag, "_ul_wr"}, ul_wr, 1'b0);
        check({tag, "_addr"}, ioctl_addr, 0);
        check({tag, "_dout"}, ioctl_dout, 0);
        check({tag, "_index"}, ioctl_index, 0);
        check({tag, "_ul_addr"}, ul_addr, 0);
        check({tag, "_ul_data"}, ul_data, 0);
        check({tag, "_src_addr"}, src_addr, 0);
    endtask

    task automatic start_dl(input logic [7:0] idx, input int len);
        for (int i = 0; i < len; i++) begin
            exp_dl_addr.push_back(i);
            exp_dl_data.push_back(img[i]);
        end
        @(posedge clk_sys); #1;
        dl_index  = idx;
        dl_length = 25'(len);
        dl_start  = 1'b1;
        @(posedge clk_sys); #1;
        dl_start  = 1'b0;
    endtask

    task automatic push_upload();
        for (int i = 0; i < 64; i++) begin
            exp_ul_addr.push_back(i);
            exp_ul_data.push_back(8'(i) ^ 8'h3C);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk_sys); #1;
            n++;
        end
        if (done_cnt == start) check({tag, "_timeout"}, done_cnt, start + 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, h0, s0, u0, n, lag, dl_done_c;
        img[0] = 8'hA5; img[1] = 8'h5A; img[2] = 8'h00; img[3] = 8'hFF;
        img[4] = 8'h11; img[5] = 8'h22; img[6] = 8'h33; img[7] = 8'h44;
        for (int i = 8; i < 16; i++) img[i] = 8'(i * 7);
        reset = 1'b1; dl_start = 1'b0; dl_index = '0; dl_length = '0;
        ul_start = 1'b0; ioctl_upload_req = 1'b0; ioctl_wait = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_zero("rst");
        reset = 1'b0;

        // 4-byte download, free-running
        w0 = wr_cyc.size(); d0 = done_cnt;
        start_dl(8'd0, 4);
        wait_done(300, "dl1");
        repeat (4) @(negedge clk_sys);
        check("dl1_nwr", wr_cyc.size() - w0, 4);
        check("dl1_done_cnt", done_cnt - d0, 1);
        if (wr_cyc.size() - w0 == 4) begin
            for (int i = 1; i < 4; i++) check("dl1_spacing", wr_cyc[w0+i] - wr_cyc[w0+i-1], 5);
            check("dl1_fall_lag", dl_fall_cyc - wr_cyc[w0+3], 4);
        end

        // Same download, ioctl_wait held 10 cycles in front of byte 2
        w0 = wr_cyc.size();
        fork
            begin
                start_dl(8'd0, 4);
                wait_done(400, "dl2");
            end
            begin
                n = 0;
                while (!(ioctl_download && src_addr == 25'd2) && n < 200) begin
                    @(negedge clk_sys);
                    n++;
                end
                check("dl2_stall_fetch", src_addr, 2);
                ioctl_wait = 1'b1;
                repeat (10) @(posedge clk_sys);
                #1;
                check("dl2_stall_addr", ioctl_addr, 1);
                check("dl2_stall_dout", ioctl_dout, 8'h5A);
                check("dl2_stall_wr", ioctl_wr, 1'b0);
                ioctl_wait = 1'b0;
            end
        join
        repeat (4) @(negedge clk_sys);
        check("dl2_nwr", wr_cyc.size() - w0, 4);
        if (wr_cyc.size() - w0 == 4) begin
            check("dl2_gap01", wr_cyc[w0+1] - wr_cyc[w0], 5);
            check("dl2_gap12", wr_cyc[w0+2] - wr_cyc[w0+1], 15);
            check("dl2_gap23", wr_cyc[w0+3] - wr_cyc[w0+2], 5);
        end

        // Zero-length download
        w0 = wr_cyc.size(); d0 = done_cnt; h0 = dl_hi;
        start_dl(8'd0, 0);
        wait_done(50, "dl0");
        repeat (3) @(negedge clk_sys);
        check("dl0_hi_cycles", dl_hi - h0, 2);
        check("dl0_nwr", wr_cyc.size() - w0, 0);
        check("dl0_done_cnt", done_cnt - d0, 1);

        // Core-requested upload
        u0 = ul_count; s0 = ul_starts;
        push_upload();
        @(posedge clk_sys); #1;
        ioctl_upload_req = 1'b1;
        wait_done(2000, "ul1");
        repeat (3) @(negedge clk_sys);
        check("ul1_count", ul_count - u0, 64);
        check("ul1_starts", ul_starts - s0, 1);
        check("ul1_fall_lag", ul_fall_cyc - ul_last_cyc, 1);
        ioctl_upload_req = 1'b0;
        repeat (3) @(posedge clk_sys);

        // Upload requested in the middle of a download
        w0 = wr_cyc.size(); u0 = ul_count; s0 = ul_starts;
        push_upload();
        start_dl(8'd7, 4);
        n = 0;
        while (wr_cyc.size() - w0 < 1 && n < 100) begin
            @(negedge clk_sys); #1;
            n++;
        end
        ioctl_upload_req = 1'b1;
        wait_done(300, "dl5");
        dl_done_c = done_cyc;
        check("dl5_nwr", wr_cyc.size() - w0, 4);
        check("dl5_no_early_ul", ul_count - u0, 0);
        wait_done(2000, "ul5");
        lag = ul_rise_cyc - dl_done_c;
        check("ul5_start_lag_ok", (lag >= 1 && lag <= 2), 1'b1);
        repeat (50) @(negedge clk_sys);
        check("ul5_count", ul_count - u0, 64);
        check("ul5_single", ul_starts - s0, 1);
        ioctl_upload_req = 1'b0;

        // Reset after the 2nd write of an 8-byte download, then restart
        w0 = wr_cyc.size();
        start_dl(8'd0, 8);
        n = 0;
        while (wr_cyc.size() - w0 < 2 && n < 100) begin
            @(negedge clk_sys); #1;
            n++;
        end
        check("rst_mid_reached", wr_cyc.size() - w0, 2);
        reset = 1'b1;
        exp_dl_addr.delete();
        exp_dl_data.delete();
        @(posedge clk_sys); #1;
        check_zero("rst_mid");
        @(posedge clk_sys); #1;
        reset = 1'b0;
        w0 = wr_cyc.size();
        repeat (20) @(negedge clk_sys);
        check("rst_no_wr", wr_cyc.size() - w0, 0);
        start_dl(8'd0, 8);
        wait_done(400, "dl6");
        check("dl6_nwr", wr_cyc.size() - w0, 8);

        repeat (5) @(negedge clk_sys);
        check("dl_q_empty", exp_dl_addr.size(), 0);
        check("ul_q_empty", exp_ul_addr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
